fp32_uart_rx_packer: RTL and testbench



---
 rtl/fp32_uart_rx_packer.sv | 185 ++++++++++++++++++
 tb/tb_fp32_uart_rx_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_uart_rx_packer.sv
// UART 8N1 receiver that packs NUM_BYTES bytes (first byte in the LSBs) into one packet on a valid/ready port.
// Latency: stop-bit sample -> RX_VALID_O 1 cycle; a held packet is kept until taken, newer completions are dropped (OVERRUN_O).
module fp32_uart_rx_packer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int NUM_BYTES    = 12,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   CLK_I,
    input  logic                   RSTL_I,
    input  logic                   UART_RX_I,
    input  logic                   RX_READY_I,
    output logic                   RX_VALID_O,
    output logic [8*NUM_BYTES-1:0] RX_DATA_O,
    output logic                   FRAME_ERR_O,
    output logic                   OVERRUN_O,
    output logic                   TIMEOUT_O
);

    localparam int CLK_W  = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
    localparam int PKT_W  = 8 * NUM_BYTES;

    localparam logic [CLK_W-1:0]  HALF_CLK  = CLK_W'(CLKS_PER_BIT / 2);
    localparam logic [CLK_W-1:0]  LAST_CLK  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
    localparam logic [IDLE_W-1:0] TO_LAST   = IDLE_W'((TO_CYC > 0) ? (TO_CYC - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q;
    logic               rx_s_q;
    logic [CLK_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [PKT_W-1:0]   asm_q, asm_d;
    logic [PKT_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
    logic               tmo_q, tmo_d;
    logic               complete;

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = '0;
        asm_d      = asm_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        tmo_d      = 1'b0;
        complete   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A partial packet left idle too long is discarded so the next byte starts a fresh packet.
                if ((TO_CYC > 0) && (byte_cnt_q != '0)) begin
                    if (idle_cnt_q == TO_LAST) begin
                        byte_cnt_d = '0;
                        tmo_d      = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                if (!rx_s_q) begin
                    state_d    = S_START;
                    clk_cnt_d  = '0;
                    idle_cnt_d = '0;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_CLK) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == LAST_CLK) begin
                    shift_d[bit_cnt_q] = rx_s_q;
                    clk_cnt_d          = '0;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            S_STOP: begin
                // Return to IDLE at mid stop bit so a back-to-back start edge is never missed.
                if (clk_cnt_q == LAST_CLK) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (rx_s_q) begin
                        asm_d[int'(byte_cnt_q)*8 +: 8] = shift_q;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            complete   = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        end
                    end else begin
                        ferr_d     = 1'b1;
                        byte_cnt_d = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A completion can reload the output in the same cycle the held packet is taken.
        if (complete) begin
            if (!valid_q || RX_READY_I) begin
                data_d  = asm_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && RX_READY_I) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            asm_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            rx_meta_q  <= UART_RX_I;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            tmo_q      <= tmo_d;
        end
    end

    assign RX_VALID_O  = valid_q;
    assign RX_DATA_O   = data_q;
    assign FRAME_ERR_O = ferr_q;
    assign OVERRUN_O   = ovr_q;
    assign TIMEOUT_O   = tmo_q;

endmodule

// File: tb/tb_fp32_uart_rx_packer.sv
// Bench for fp32_uart_rx_packer: a 12-byte instance with timeout and a 1-byte instance without,
// expected packets queued as they are sent and compared when the consumer takes them.
module tb_fp32_uart_rx_packer;

    localparam int CPB = 16;
    localparam int NB  = 12;
    localparam int TOB = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx, rx1, ready, ready1;
    logic          valid, valid1;
    logic [8*NB-1:0] data;
    logic [7:0]    data1;
    logic          ferr, ovr, tmo, ferr1, ovr1, tmo1;

    int n_checks = 0;
    int n_err    = 0;
    int xfer_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, tmo_cnt = 0;
    int xfer1_cnt = 0, ferr1_cnt = 0, ovr1_cnt = 0, tmo1_cnt = 0;
    logic [95:0] sb[$];
    logic [95:0] sb1[$];

    always #5 clk = ~clk;

    fp32_uart_rx_packer #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_BITS(TOB)) dut (
        .CLK_I(clk), .RSTL_I(rst_n), .UART_RX_I(rx), .RX_READY_I(ready),
        .RX_VALID_O(valid), .RX_DATA_O(data),
        .FRAME_ERR_O(ferr), .OVERRUN_O(ovr), .TIMEOUT_O(tmo)
    );

    fp32_uart_rx_packer #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1), .TIMEOUT_BITS(0)) dut1 (
        .CLK_I(clk), .RSTL_I(rst_n), .UART_RX_I(rx1), .RX_READY_I(ready1),
        .RX_VALID_O(valid1), .RX_DATA_O(data1),
        .FRAME_ERR_O(ferr1), .OVERRUN_O(ovr1), .TIMEOUT_O(tmo1)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sampled mid-cycle, after inputs driven at the falling edge have settled.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (valid && ready) begin
                xfer_cnt++;
                check("sb_has_exp", 96'(sb.size() > 0), 96'd1);
                if (sb.size() > 0) check("pkt", data, sb.pop_front());
            end
            if (valid1 && ready1) begin
                xfer1_cnt++;
                check("sb1_has_exp", 96'(sb1.size() > 0), 96'd1);
                if (sb1.size() > 0) check("pkt1", {88'd0, data1}, sb1.pop_front());
            end
            if (ferr)  ferr_cnt++;
            if (ovr)   ovr_cnt++;
            if (tmo)   tmo_cnt++;
            if (ferr1) ferr1_cnt++;
            if (ovr1)  ovr1_cnt++;
            if (tmo1)  tmo1_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [95:0] mk_pkt(input logic [7:0] base);
        logic [95:0] p;
        for (int i = 0; i < NB; i++) p[8*i +: 8] = base + 8'(i);
        return p;
    endfunction

    task automatic send_bit(input bit which, input logic v);
        if (which) rx1 = v; else rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input bit which, input logic [7:0] b, input logic stop);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, b[i]);
        send_bit(which, stop);
    endtask

    task automatic send_pkt(input logic [95:0] p);
        for (int i = 0; i < NB; i++) send_byte(1'b0, p[8*i +: 8], 1'b1);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
        check(tag, 96'(sb.size()), 96'd0);
    endtask

    initial begin
        logic [95:0] p;
        int k, f0, o0, t0, x0;
        rst_n = 1'b0; rx = 1'b1; rx1 = 1'b1; ready = 1'b1; ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 96'(valid), 96'd0);
        check("rst_data", data, 96'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("init_valid", 96'(valid), 96'd0);
        check("init_pulses", {93'd0, ferr, ovr, tmo}, 96'd0);
        check("init_valid1", 96'(valid1), 96'd0);

        // Back-to-back packet with consumer always ready
        p = mk_pkt(8'h00);
        check("pkt_const", p, 96'h0B0A09080706050403020100);
        sb.push_back(p);
        send_pkt(p);
        drain("drain1", 100);
        check("t1_xfers", 96'(xfer_cnt), 96'd1);
        check("t1_errs", 96'(ferr_cnt + ovr_cnt + tmo_cnt), 96'd0);

        // Backpressure: held packet, then a second completion is dropped
        ready = 1'b0;
        sb.push_back(p);
        send_pkt(p);
        repeat (2) @(negedge clk);
        check("hold_valid", 96'(valid), 96'd1);
        check("hold_data", data, p);
        repeat (500) @(negedge clk);
        check("hold500_valid", 96'(valid), 96'd1);
        check("hold500_data", data, p);
        send_pkt(mk_pkt(8'h10));
        repeat (2) @(negedge clk);
        check("ovr_cnt", 96'(ovr_cnt), 96'd1);
        check("ovr_data", data, p);
        ready = 1'b1;
        drain("drain2", 20);
        @(negedge clk);
        check("t2_xfers", 96'(xfer_cnt), 96'd2);
        check("t2_valid_low", 96'(valid), 96'd0);

        // Framing error on byte 5 aborts the packet
        for (int i = 0; i < 5; i++) send_byte(1'b0, 8'h50 + 8'(i), 1'b1);
        send_byte(1'b0, 8'h55, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        check("ferr_cnt", 96'(ferr_cnt), 96'd1);
        check("ferr_no_xfer", 96'(xfer_cnt), 96'd2);
        p = '1;
        sb.push_back(p);
        send_pkt(p);
        drain("drain3", 100);
        check("t3_xfers", 96'(xfer_cnt), 96'd3);

        // Partial packet times out 320 cycles after the 4th stop sample
        for (int i = 0; i < 4; i++) send_byte(1'b0, 8'h40 + 8'(i), 1'b1);
        k = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (tmo) begin
                k = i;
                break;
            end
        end
        check("tmo_delay", 96'(k), 96'd316);
        @(negedge clk);
        check("tmo_pulse_w", 96'(tmo), 96'd0);
        check("tmo_cnt", 96'(tmo_cnt), 96'd1);
        check("tmo_valid", 96'(valid), 96'd0);
        p = mk_pkt(8'h20);
        sb.push_back(p);
        send_pkt(p);
        drain("drain4", 100);
        check("t4_xfers", 96'(xfer_cnt), 96'd4);

        // Short low glitch is ignored
        f0 = ferr_cnt; o0 = ovr_cnt; t0 = tmo_cnt; x0 = xfer_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3*CPB) @(negedge clk);
        check("glitch_cnts", 96'((ferr_cnt - f0) + (ovr_cnt - o0) + (tmo_cnt - t0) + (xfer_cnt - x0)), 96'd0);
        check("glitch_valid", 96'(valid), 96'd0);

        // Reset mid byte 7 drops both the held and the partial packet
        ready = 1'b0;
        send_pkt(mk_pkt(8'h60));
        repeat (2) @(negedge clk);
        check("pre_rst_valid", 96'(valid), 96'd1);
        for (int i = 0; i < 7; i++) send_byte(1'b0, 8'h70 + 8'(i), 1'b1);
        send_bit(1'b0, 1'b0);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 96'(valid), 96'd0);
        check("midrst_data", data, 96'd0);
        check("midrst_pulses", {93'd0, ferr, ovr, tmo}, 96'd0);
        repeat (3) @(negedge clk);
        ready = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        p = mk_pkt(8'h80);
        sb.push_back(p);
        send_pkt(p);
        drain("drain5", 100);
        check("t5_xfers", 96'(xfer_cnt), 96'd5);

        // Single-byte packets, timeout disabled
        sb1.push_back(96'hA5);
        sb1.push_back(96'h3C);
        sb1.push_back(96'h81);
        send_byte(1'b1, 8'hA5, 1'b1);
        send_byte(1'b1, 8'h3C, 1'b1);
        send_byte(1'b1, 8'h81, 1'b1);
        repeat (400) @(negedge clk);
        check("nb1_xfers", 96'(xfer1_cnt), 96'd3);
        check("nb1_sb_empty", 96'(sb1.size()), 96'd0);
        check("nb1_no_tmo", 96'(tmo1_cnt + ferr1_cnt + ovr1_cnt), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
